// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   VGA raster timing generator. A clock divider produces one pixel slot every
//   CLK_DIV clk cycles. The horizontal and vertical counters advance once per
//   pixel slot. Sync, visible-area and frame strobes are decoded from the
//   counters.
//
// Ports:
//   clk         in   system clock. All state changes on the rising edge.
//   rst         in   synchronous, active-high reset
//   hCount      out  [9:0] current pixel column, 0..H_TOTAL-1
//   vCount      out  [9:0] current line, 0..V_TOTAL-1
//   hSync       out  active-low horizontal sync, registered
//   vSync       out  active-low vertical sync, registered
//   bright      out  high inside the visible window, registered
//   pix_en      out  high in the last clk of each pixel period (combinational)
//   frame_tick  out  one-clk pulse that follows the frame wrap to (0,0)
//   frame_count out  [7:0] free-running frame counter, modulo 256
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV      = 4,
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC       = 96,
    parameter int H_DISP_START = 144,
    parameter int H_DISP_END   = 783,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC       = 2,
    parameter int V_DISP_START = 35,
    parameter int V_DISP_END   = 514
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       pix_en,
    output logic       frame_tick,
    output logic [7:0] frame_count
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
    localparam logic [9:0] H_VIS_LO  = 10'(H_DISP_START);
    localparam logic [9:0] H_VIS_HI  = 10'(H_DISP_END);
    localparam logic [9:0] V_VIS_LO  = 10'(V_DISP_START);
    localparam logic [9:0] V_VIS_HI  = 10'(V_DISP_END);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             bright_q, bright_d;
    logic             tick_q, tick_d;
    logic [7:0]       fcount_q, fcount_d;
    logic             advance;
    logic             frame_wrap;

    assign advance = (div_q == DIV_LAST);

    always_comb begin
        div_d      = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        h_d        = h_q;
        v_d        = v_q;
        frame_wrap = 1'b0;

        if (advance) begin
            if (h_q < H_LAST) begin
                h_d = h_q + 10'd1;
            end else begin
                h_d = 10'd0;
                if (v_q < V_LAST) begin
                    v_d = v_q + 10'd1;
                end else begin
                    v_d        = 10'd0;
                    frame_wrap = 1'b1;
                end
            end
        end

        // The decodes use the next counter values. The registered strobes then
        // line up with the counters they describe, with no one-pixel lag.
        hsync_d  = (h_d >= H_SYNC_W);
        vsync_d  = (v_d >= V_SYNC_W);
        bright_d = (h_d >= H_VIS_LO) && (h_d <= H_VIS_HI) &&
                   (v_d >= V_VIS_LO) && (v_d <= V_VIS_HI);
        tick_d   = frame_wrap;
        fcount_d = frame_wrap ? fcount_q + 8'd1 : fcount_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            h_q      <= 10'd0;
            v_q      <= 10'd0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            bright_q <= 1'b0;
            tick_q   <= 1'b0;
            fcount_q <= 8'd0;
        end else begin
            div_q    <= div_d;
            h_q      <= h_d;
            v_q      <= v_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            bright_q <= bright_d;
            tick_q   <= tick_d;
            fcount_q <= fcount_d;
        end
    end

    assign hCount      = h_q;
    assign vCount      = v_q;
    assign hSync       = hsync_q;
    assign vSync       = vsync_q;
    assign bright      = bright_q;
    assign pix_en      = advance;
    assign frame_tick  = tick_q;
    assign frame_count = fcount_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Self-checking bench for vga_timing_gen. The bench uses a small raster so that
// more than 256 frames fit into a short run. The reference model works from
// the number of clk edges since reset. That count is split into a pixel index,
// a frame number and a divider phase with plain division.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int CD  = 3;
    localparam int HT  = 8;
    localparam int HS  = 2;
    localparam int HDS = 3;
    localparam int HDE = 6;
    localparam int VT  = 6;
    localparam int VS  = 1;
    localparam int VDS = 2;
    localparam int VDE = 4;
    localparam int FRAME_PIX = HT * VT;
    localparam int FRAME_CLK = FRAME_PIX * CD;

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       br;
        logic       pe;
        logic       ft;
        logic [7:0] fc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       hSync;
    logic       vSync;
    logic       bright;
    logic       pix_en;
    logic       frame_tick;
    logic [7:0] frame_count;

    int     tests = 0;
    int     fails = 0;
    longint n     = 0;  // clk edges since the last reset edge

    vga_timing_gen #(
        .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS),
        .H_DISP_START(HDS), .H_DISP_END(HDE),
        .V_TOTAL(VT), .V_SYNC(VS),
        .V_DISP_START(VDS), .V_DISP_END(VDE)
    ) dut (
        .clk(clk), .rst(rst),
        .hCount(hCount), .vCount(vCount),
        .hSync(hSync), .vSync(vSync), .bright(bright),
        .pix_en(pix_en), .frame_tick(frame_tick), .frame_count(frame_count)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    // ---------------- reference model ----------------
    function automatic exp_t model(input longint t);
        exp_t   e;
        longint adv;
        longint pix;
        int     hh;
        int     vv;
        adv  = t / CD;
        pix  = adv % FRAME_PIX;
        hh   = int'(pix % HT);
        vv   = int'(pix / HT);
        e.h  = 10'(hh);
        e.v  = 10'(vv);
        e.hs = (hh >= HS);
        e.vs = (vv >= VS);
        e.br = (hh >= HDS) && (hh <= HDE) && (vv >= VDS) && (vv <= VDE);
        e.pe = ((t % CD) == CD - 1);
        e.ft = (t > 0) && ((t % CD) == 0) && (pix == 0);
        e.fc = 8'((adv / FRAME_PIX) % 256);
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    // Leaves the bench at a falling edge that follows exactly one reset edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (hCount !== 10'd0) begin fails++; $display("FAIL reset_hcount got %0d exp 0", hCount); end
        tests++; if (vCount !== 10'd0) begin fails++; $display("FAIL reset_vcount got %0d exp 0", vCount); end
        tests++; if (hSync !== 1'b0) begin fails++; $display("FAIL reset_hsync got %b exp 0", hSync); end
        tests++; if (vSync !== 1'b0) begin fails++; $display("FAIL reset_vsync got %b exp 0", vSync); end
        tests++; if (bright !== 1'b0) begin fails++; $display("FAIL reset_bright got %b exp 0", bright); end
        tests++; if (pix_en !== 1'b0) begin fails++; $display("FAIL reset_pix_en got %b exp 0", pix_en); end
        tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_frame_tick got %b exp 0", frame_tick); end
        tests++; if (frame_count !== 8'd0) begin fails++; $display("FAIL reset_frame_count got %0d exp 0", frame_count); end
    endtask

    task automatic test_reset_release();
        rst = 1'b0;
        repeat (CD - 1) @(negedge clk);
        tests++; if (pix_en !== 1'b1) begin fails++; $display("FAIL release_pix_en got %b exp 1", pix_en); end
        tests++; if (hCount !== 10'd0) begin fails++; $display("FAIL release_hold_hcount got %0d exp 0", hCount); end
        @(negedge clk);
        tests++; if (hCount !== 10'd1) begin fails++; $display("FAIL release_hcount got %0d exp 1", hCount); end
        tests++; if (vCount !== 10'd0) begin fails++; $display("FAIL release_vcount got %0d exp 0", vCount); end
        tests++; if (hSync !== 1'b0) begin fails++; $display("FAIL release_hsync got %b exp 0", hSync); end
        tests++; if (bright !== 1'b0) begin fails++; $display("FAIL release_bright got %b exp 0", bright); end
        tests++; if (pix_en !== 1'b0) begin fails++; $display("FAIL release_pix_en_low got %b exp 0", pix_en); end
    endtask

    task automatic test_line_timing();
        int         low;
        int         seen;
        logic [9:0] prev_h;
        logic [9:0] prev_v;
        low  = 0;
        seen = 0;
        do_reset();
        prev_h = hCount;
        prev_v = vCount;
        for (int c = 0; c <= HT * CD; c++) begin
            if (c > 0) @(negedge clk);
            if (c < HT * CD && hSync == 1'b0) low++;
            if (c > 0 && int'(prev_h) == HT - 1 && hCount != prev_h) begin
                seen++;
                tests++;
                if (hCount !== 10'd0 || int'(vCount) != int'(prev_v) + 1) begin
                    fails++;
                    $display("FAIL line_wrap got h=%0d v=%0d exp h=0 v=%0d", hCount, vCount, int'(prev_v) + 1);
                end
            end
            prev_h = hCount;
            prev_v = vCount;
        end
        tests++; if (low != HS * CD) begin fails++; $display("FAIL line_hsync_low got %0d clks exp %0d", low, HS * CD); end
        tests++; if (seen != 1) begin fails++; $display("FAIL line_wrap_seen got %0d exp 1", seen); end
    endtask

    task automatic test_visible_window();
        int   hits;
        int   bad;
        exp_t e;
        hits = 0;
        bad  = 0;
        do_reset();
        for (int c = 0; c < FRAME_CLK; c++) begin
            if (c > 0) @(negedge clk);
            e = model(n);
            if (bright !== e.br || hSync !== e.hs || vSync !== e.vs) begin
                bad++;
                $display("FAIL window_decode n=%0d got br=%b hs=%b vs=%b exp br=%b hs=%b vs=%b",
                         n, bright, hSync, vSync, e.br, e.hs, e.vs);
            end
            if (int'(hCount) == HDS && int'(vCount) == VDS) begin
                hits++; tests++;
                if (bright !== 1'b1) begin fails++; $display("FAIL window_rise got %b exp 1", bright); end
            end
            if (int'(hCount) == HDE + 1 && int'(vCount) == VDS) begin
                hits++; tests++;
                if (bright !== 1'b0) begin fails++; $display("FAIL window_fall got %b exp 0", bright); end
            end
            if (int'(hCount) == HDS && int'(vCount) == VDS - 1) begin
                hits++; tests++;
                if (bright !== 1'b0) begin fails++; $display("FAIL window_above got %b exp 0", bright); end
            end
            if (int'(hCount) == HDS && int'(vCount) == VDE + 1) begin
                hits++; tests++;
                if (bright !== 1'b0) begin fails++; $display("FAIL window_below got %b exp 0", bright); end
            end
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL window_sweep got %0d bad cycles exp 0", bad); end
        tests++; if (hits != 4 * CD) begin fails++; $display("FAIL window_hits got %0d exp %0d", hits, 4 * CD); end
    endtask

    task automatic test_frame_wrap();
        int         c;
        int         gap;
        logic [9:0] prev_h;
        logic [9:0] prev_v;
        do_reset();
        c = 0;
        prev_h = hCount;
        prev_v = vCount;
        while (frame_tick !== 1'b1 && c < 2 * FRAME_CLK) begin
            prev_h = hCount;
            prev_v = vCount;
            @(negedge clk);
            c++;
        end
        tests++; if (c != FRAME_CLK) begin fails++; $display("FAIL wrap_first_tick got %0d clks exp %0d", c, FRAME_CLK); end
        tests++; if (int'(prev_h) != HT - 1 || int'(prev_v) != VT - 1) begin
            fails++; $display("FAIL wrap_from got (%0d,%0d) exp (%0d,%0d)", prev_h, prev_v, HT - 1, VT - 1);
        end
        tests++; if (hCount !== 10'd0 || vCount !== 10'd0) begin
            fails++; $display("FAIL wrap_to got (%0d,%0d) exp (0,0)", hCount, vCount);
        end
        tests++; if (frame_count !== 8'd1) begin fails++; $display("FAIL wrap_count got %0d exp 1", frame_count); end
        @(negedge clk);
        tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL wrap_tick_width got %b exp 0", frame_tick); end
        gap = 1;
        while (frame_tick !== 1'b1 && gap < 2 * FRAME_CLK) begin
            @(negedge clk);
            gap++;
        end
        tests++; if (gap != FRAME_CLK) begin fails++; $display("FAIL wrap_period got %0d clks exp %0d", gap, FRAME_CLK); end
        tests++; if (frame_count !== 8'd2) begin fails++; $display("FAIL wrap_count2 got %0d exp 2", frame_count); end
    endtask

    task automatic test_counter_wrap();
        int ticks;
        int c;
        do_reset();
        ticks = 0;
        c = 0;
        while (ticks < 256 && c < 257 * FRAME_CLK) begin
            @(negedge clk);
            c++;
            if (frame_tick === 1'b1) begin
                ticks++;
                tests++;
                if (int'(frame_count) != ticks % 256 || c != ticks * FRAME_CLK) begin
                    fails++;
                    $display("FAIL cnt_tick got count=%0d at clk %0d exp count=%0d at clk %0d",
                             frame_count, c, ticks % 256, ticks * FRAME_CLK);
                end
            end
        end
        tests++; if (ticks != 256) begin fails++; $display("FAIL cnt_ticks got %0d exp 256", ticks); end
        tests++; if (frame_count !== 8'd0) begin fails++; $display("FAIL cnt_wrap got %0d exp 0", frame_count); end
        @(negedge clk);
        tests++; if (frame_tick !== 1'b0) begin fails++; $display("FAIL cnt_tick_width got %b exp 0", frame_tick); end
    endtask

    task automatic test_mid_reset();
        int c;
        int tick_seen;
        do_reset();
        c = 0;
        // Stop on the second frame at pixel (4,3), divider phase 2.
        while (!(hCount == 10'd4 && vCount == 10'd3 && (n % CD) == 2 && frame_count == 8'd1)
               && c < 3 * FRAME_CLK) begin
            @(negedge clk);
            c++;
        end
        tests++; if (c >= 3 * FRAME_CLK) begin fails++; $display("FAIL midrst_reach got %0d clks exp < %0d", c, 3 * FRAME_CLK); end
        rst = 1'b1;
        @(negedge clk);
        tests++; if (hCount !== 10'd0 || vCount !== 10'd0) begin
            fails++; $display("FAIL midrst_counters got (%0d,%0d) exp (0,0)", hCount, vCount);
        end
        tests++; if (hSync !== 1'b0 || vSync !== 1'b0 || bright !== 1'b0) begin
            fails++; $display("FAIL midrst_strobes got hs=%b vs=%b br=%b exp 0 0 0", hSync, vSync, bright);
        end
        tests++; if (frame_tick !== 1'b0 || frame_count !== 8'd0) begin
            fails++; $display("FAIL midrst_frame got tick=%b count=%0d exp 0 0", frame_tick, frame_count);
        end
        tests++; if (pix_en !== 1'b0) begin fails++; $display("FAIL midrst_pix_en got %b exp 0", pix_en); end
        rst = 1'b0;
        c = 0;
        tick_seen = 0;
        while (hCount == 10'd0 && c < 4 * CD) begin
            @(negedge clk);
            c++;
            if (frame_tick === 1'b1) tick_seen++;
        end
        tests++; if (c != CD) begin fails++; $display("FAIL midrst_first_adv got %0d clks exp %0d", c, CD); end
        tests++; if (tick_seen != 0 || frame_count !== 8'd0) begin
            fails++; $display("FAIL midrst_no_tick got ticks=%0d count=%0d exp 0 0", tick_seen, frame_count);
        end
    endtask

    task automatic test_random();
        exp_t e;
        int   len;
        int   rlen;
        do_reset();
        for (int it = 0; it < 24; it++) begin
            len = int'($urandom_range(1, 3 * FRAME_CLK));
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                e = model(n);
                tests++; if (hCount !== e.h) begin fails++; $display("FAIL rand_hcount n=%0d got %0d exp %0d", n, hCount, e.h); end
                tests++; if (vCount !== e.v) begin fails++; $display("FAIL rand_vcount n=%0d got %0d exp %0d", n, vCount, e.v); end
                tests++; if (hSync !== e.hs) begin fails++; $display("FAIL rand_hsync n=%0d got %b exp %b", n, hSync, e.hs); end
                tests++; if (vSync !== e.vs) begin fails++; $display("FAIL rand_vsync n=%0d got %b exp %b", n, vSync, e.vs); end
                tests++; if (bright !== e.br) begin fails++; $display("FAIL rand_bright n=%0d got %b exp %b", n, bright, e.br); end
                tests++; if (pix_en !== e.pe) begin fails++; $display("FAIL rand_pix_en n=%0d got %b exp %b", n, pix_en, e.pe); end
                tests++; if (frame_tick !== e.ft) begin fails++; $display("FAIL rand_tick n=%0d got %b exp %b", n, frame_tick, e.ft); end
                tests++; if (frame_count !== e.fc) begin fails++; $display("FAIL rand_count n=%0d got %0d exp %0d", n, frame_count, e.fc); end
                if (rst) rst = 1'b0;
            end
            // A random reset pulse of 1..3 clks lands at an arbitrary pixel and divider phase.
            if ($urandom_range(0, 1) == 1) begin
                rlen = int'($urandom_range(1, 3));
                rst = 1'b1;
                repeat (rlen - 1) @(negedge clk);
            end
        end
        rst = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_reset_release();
        test_line_timing();
        test_visible_window();
        test_frame_wrap();
        test_mid_reset();
        test_random();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 4, the number of clk cycles per pixel (100 MHz clk gives a 25 MHz pixel rate); legal values are 2 or more.
REQ-002 The module SHALL have parameter H_TOTAL, default 800, the pixels per line (counts 0..H_TOTAL-1).
REQ-003 The module SHALL have parameter H_SYNC, default 96, the hSync pulse width in pixels.
REQ-004 The module SHALL have parameter H_DISP_START, default 144, the first visible hCount; H_DISP_END, default 783, is the last visible hCount.
REQ-005 The module SHALL have parameter V_TOTAL, default 525, the lines per frame (counts 0..V_TOTAL-1).
REQ-006 The module SHALL have parameter V_SYNC, default 2, the vSync pulse width in lines.
REQ-007 The module SHALL have parameter V_DISP_START, default 35, the first visible vCount; V_DISP_END, default 514, is the last visible vCount.
REQ-008 Ports SHALL be: clk, input, 1 bit, the single system clock; all logic runs on its rising edge.
REQ-009 Ports SHALL include: rst, input, 1 bit, synchronous active-high reset.
REQ-010 Ports SHALL include: hCount, output, 10 bits, current pixel column.
REQ-011 Ports SHALL include: vCount, output, 10 bits, current line.
REQ-012 Ports SHALL include: hSync, output, 1 bit, active-low horizontal sync.
REQ-013 Ports SHALL include: vSync, output, 1 bit, active-low vertical sync.
REQ-014 Ports SHALL include: bright, output, 1 bit, high inside the visible area.
REQ-015 Ports SHALL include: pix_en, output, 1 bit, high in the last clk of each pixel period.
REQ-016 Ports SHALL include: frame_tick, output, 1 bit, one-clk pulse per frame, used as the game-update strobe.
REQ-017 Ports SHALL include: frame_count, output, 8 bits, free-running frame counter.

Function
REQ-018 An internal divider SHALL count 0..CLK_DIV-1 on every clk and wrap to 0.
REQ-019 pix_en SHALL be combinational: pix_en = (divider == CLK_DIV-1).
REQ-020 hCount and vCount SHALL change only on a clk edge where pix_en = 1; at all other times they hold.
REQ-021 On an advancing edge, if hCount < H_TOTAL-1, hCount SHALL increment by 1; otherwise hCount SHALL go to 0 and the vertical step SHALL apply.
REQ-022 In the vertical step, if vCount < V_TOTAL-1, vCount SHALL increment by 1; otherwise vCount SHALL go to 0 (frame wrap).
REQ-023 hSync, vSync and bright SHALL be registered, decoded from the next counter values, so that they always match the hCount/vCount currently on the outputs with zero relative skew.
REQ-024 hSync SHALL be 0 when hCount is in 0..H_SYNC-1 and 1 otherwise.
REQ-025 vSync SHALL be 0 when vCount is in 0..V_SYNC-1 and 1 otherwise.
REQ-026 bright SHALL be 1 exactly when H_DISP_START <= hCount <= H_DISP_END and V_DISP_START <= vCount <= V_DISP_END.
REQ-027 frame_tick SHALL be registered and high for exactly one clk, the clk immediately after the edge that produces the frame wrap to (0,0); at all other times it SHALL be 0.
REQ-028 frame_count SHALL increment by 1 on the frame-wrap edge, modulo 256 (255 wraps to 0), and SHALL be valid in the same cycle that frame_tick is high.
REQ-029 All counter comparisons SHALL be unsigned, 10-bit; counters SHALL never exceed H_TOTAL-1 or V_TOTAL-1.
REQ-030 A frame SHALL last exactly H_TOTAL*V_TOTAL*CLK_DIV clk cycles (1,680,000 with defaults).

Reset
REQ-031 When rst = 1 at a clk edge, the module SHALL set divider, hCount, vCount and frame_count to 0.
REQ-032 When rst = 1 at a clk edge, the module SHALL set hSync = 0, vSync = 0, bright = 0 and frame_tick = 0.
REQ-033 rst SHALL take priority over advancing, including mid-line and mid-pixel; no frame_tick and no frame_count increment SHALL result from a reset.
REQ-034 After rst is deasserted, the first advancing edge SHALL be the CLK_DIV-th clk edge.

Verification
REQ-035 Reset release scenario: deassert rst, then apply 4 clk edges -> pix_en is high during the 4th cycle, hCount = 1 after the 4th edge, vCount = 0, hSync = 0, bright = 0.
REQ-036 Line timing scenario: run one full line -> hSync is low for 384 clks (hCount 0..95); hCount goes 799 -> 0 while vCount goes 0 -> 1 on the same edge.
REQ-037 Visible window scenario: bright rises when (hCount, vCount) = (144, 35), falls at (784, 35), is low at (144, 34) and at (144, 515), and is low throughout vCount 0..1.
REQ-038 Frame wrap scenario: (799, 524) advances to (0, 0) -> frame_tick is high for exactly 1 clk; frame_count 0 -> 1; the next frame_tick arrives 1,680,000 clks later.
REQ-039 Counter wrap scenario: preload by running 255 frames, then complete one more frame -> frame_count goes 255 -> 0 and frame_tick still pulses once.
REQ-040 Mid-operation reset scenario: assert rst for 1 clk at (400, 200) with divider = 2 -> on the next edge all outputs equal the reset values, and the next advancing edge occurs 4 clks after rst falls.
